pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: resolves external stalls, branch flushes and
// load-use hazards into per-register hold/bubble controls plus a stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned NSTAGE    = 4,
    parameter int unsigned REGW      = 3,
    parameter int unsigned LU_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_stall,
    input  logic              mem_stall,
    input  logic              ex_memRead,
    input  logic [REGW-1:0]   ex_rd,
    input  logic [REGW-1:0]   id_rs,
    input  logic [REGW-1:0]   id_rt,
    input  logic              id_rs_valid,
    input  logic              id_rt_valid,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic              pc_hold,
    output logic [NSTAGE-1:0] hold,
    output logic [NSTAGE-1:0] bubble,
    output logic              lu_busy,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned LU_CNT_W  = 3;
    localparam int unsigned CNT_W     = 16;
    localparam logic [LU_CNT_W-1:0] LU_RELOAD = LU_CNT_W'(LU_CYCLES - 1);
    localparam logic                MULTI_LU  = (LU_CYCLES > 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LU_WAIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic ext_stall;
    logic hazard;

    assign ext_stall = fetch_stall | mem_stall;
    assign hazard    = ex_memRead & ((id_rs_valid & (id_rs == ex_rd)) |
                                     (id_rt_valid & (id_rt == ex_rd)));

    // Prioritised hazard decode and load-use wait sequencing
    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        pc_hold  = 1'b0;
        hold     = '0;
        bubble   = '0;
        if (rst) begin
            bubble = '1;
        end else if (ext_stall) begin
            // whole pipe frozen; the held EX stage re-presents flush/hazard later
            pc_hold = 1'b1;
            hold    = '1;
        end else if (flush) begin
            bubble[0] = 1'b1;
            bubble[1] = 1'b1;
            state_d   = ST_RUN;
            lu_cnt_d  = '0;
        end else if (hazard || (state_q == ST_LU_WAIT)) begin
            pc_hold   = 1'b1;
            hold[0]   = 1'b1;
            bubble[1] = 1'b1;
            if (state_q == ST_LU_WAIT) begin
                // remaining bubbles already committed; hazard not re-checked here
                if (lu_cnt_q <= LU_CNT_W'(1)) begin
                    state_d  = ST_RUN;
                    lu_cnt_d = '0;
                end else begin
                    lu_cnt_d = lu_cnt_q - LU_CNT_W'(1);
                end
            end else if (MULTI_LU) begin
                state_d  = ST_LU_WAIT;
                lu_cnt_d = LU_RELOAD;
            end
        end
    end

    // Saturating count of PC-hold cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (pc_hold && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            lu_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign lu_busy   = (state_q == ST_LU_WAIT) & ~rst;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: two instances (LU_CYCLES=1/NSTAGE=4 and
// LU_CYCLES=3/NSTAGE=6) share inputs and are checked against a
// bubble-budget reference model, a vector table and directed sequences.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, fetch_stall, mem_stall, ex_memRead;
    logic [2:0] ex_rd, id_rs, id_rt;
    logic       id_rs_valid, id_rt_valid, flush, cnt_clr;

    logic        pc_hold_a, lu_busy_a;
    logic [3:0]  hold_a, bubble_a;
    logic [15:0] stall_cnt_a;
    logic        pc_hold_b, lu_busy_b;
    logic [5:0]  hold_b, bubble_b;
    logic [15:0] stall_cnt_b;

    pipe_hazard_ctrl #(.NSTAGE(4), .REGW(3), .LU_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .fetch_stall(fetch_stall), .mem_stall(mem_stall),
        .ex_memRead(ex_memRead), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid), .flush(flush),
        .cnt_clr(cnt_clr), .pc_hold(pc_hold_a), .hold(hold_a), .bubble(bubble_a),
        .lu_busy(lu_busy_a), .stall_cnt(stall_cnt_a)
    );

    pipe_hazard_ctrl #(.NSTAGE(6), .REGW(3), .LU_CYCLES(3)) u_b (
        .clk(clk), .rst(rst), .fetch_stall(fetch_stall), .mem_stall(mem_stall),
        .ex_memRead(ex_memRead), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid), .flush(flush),
        .cnt_clr(cnt_clr), .pc_hold(pc_hold_b), .hold(hold_b), .bubble(bubble_b),
        .lu_busy(lu_busy_b), .stall_cnt(stall_cnt_b)
    );

    int total = 0;
    int bad   = 0;

    // reference model: bubbles still owed and the stall count, per instance
    int rem [2];
    int cnt [2];

    // last sampled DUT outputs, per instance
    logic        s_pc   [2];
    logic [7:0]  s_hold [2];
    logic [7:0]  s_bub  [2];
    logic        s_busy [2];
    logic [15:0] s_cnt  [2];

    function automatic int luc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int nst(input int i);
        return (i == 0) ? 4 : 6;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic fs, input logic ms, input logic mr,
                         input logic [2:0] rd, input logic [2:0] rs, input logic rsv,
                         input logic [2:0] rt, input logic rtv, input logic fl,
                         input logic clr);
        rst = r; fetch_stall = fs; mem_stall = ms; ex_memRead = mr;
        ex_rd = rd; id_rs = rs; id_rs_valid = rsv; id_rt = rt; id_rt_valid = rtv;
        flush = fl; cnt_clr = clr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 3'd0, 3'd1, 0, 3'd2, 0, 0, 0);
    endtask

    // one clock: sample at negedge, compare to model, advance model to the next edge
    task automatic step(input bit do_chk);
        logic       hz, ext, e_pc, e_busy;
        logic [7:0] e_hold, e_bub, mask;
        @(negedge clk);
        s_pc[0] = pc_hold_a; s_hold[0] = 8'(hold_a); s_bub[0] = 8'(bubble_a);
        s_busy[0] = lu_busy_a; s_cnt[0] = stall_cnt_a;
        s_pc[1] = pc_hold_b; s_hold[1] = 8'(hold_b); s_bub[1] = 8'(bubble_b);
        s_busy[1] = lu_busy_b; s_cnt[1] = stall_cnt_b;
        hz  = ex_memRead && ((id_rs_valid && id_rs == ex_rd) || (id_rt_valid && id_rt == ex_rd));
        ext = fetch_stall || mem_stall;
        for (int i = 0; i < 2; i++) begin
            mask   = 8'((1 << nst(i)) - 1);
            e_pc   = 1'b0;
            e_hold = 8'h00;
            e_bub  = 8'h00;
            e_busy = !rst && (rem[i] > 0);
            if (rst) begin
                e_bub = mask;
            end else if (ext) begin
                e_pc = 1'b1; e_hold = mask;
            end else if (flush) begin
                e_bub = 8'h03;
            end else if (rem[i] > 0 || hz) begin
                e_pc = 1'b1; e_hold = 8'h01; e_bub = 8'h02;
            end
            if (do_chk) begin
                chk($sformatf("pc_hold[%0d]", i), 32'(s_pc[i]), 32'(e_pc));
                chk($sformatf("hold[%0d]", i), 32'(s_hold[i]), 32'(e_hold));
                chk($sformatf("bubble[%0d]", i), 32'(s_bub[i]), 32'(e_bub));
                chk($sformatf("lu_busy[%0d]", i), 32'(s_busy[i]), 32'(e_busy));
                chk($sformatf("stall_cnt[%0d]", i), 32'(s_cnt[i]), 32'(cnt[i]));
            end
            if (rst) begin
                rem[i] = 0;
                cnt[i] = 0;
            end else begin
                if (!ext) begin
                    if (flush)           rem[i] = 0;
                    else if (rem[i] > 0) rem[i] = rem[i] - 1;
                    else if (hz)         rem[i] = luc(i) - 1;
                end
                if (cnt_clr)                     cnt[i] = 0;
                else if (e_pc && cnt[i] < 65535) cnt[i] = cnt[i] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r, fs, ms, mr;
        logic [2:0] rd, rs;
        logic       rsv;
        logic [2:0] rt;
        logic       rtv, fl;
        logic       e_pc;
        logic [3:0] e_hold, e_bub;
    } vec_t;

    vec_t vecs [11];
    int   nbub;

    initial begin
        rem[0] = 0; rem[1] = 0; cnt[0] = 0; cnt[1] = 0;
        // rst fs ms mr rd rs rsv rt rtv fl | pc hold bubble   (NSTAGE=4, LU_CYCLES=1)
        vecs[0]  = '{1, 1, 0, 1, 3'd3, 3'd3, 1, 3'd0, 0, 1, 0, 4'h0, 4'hF};
        vecs[1]  = '{0, 0, 0, 0, 3'd0, 3'd1, 0, 3'd2, 0, 0, 0, 4'h0, 4'h0};
        vecs[2]  = '{0, 0, 0, 1, 3'd3, 3'd3, 1, 3'd1, 1, 0, 1, 4'h1, 4'h2};
        vecs[3]  = '{0, 0, 0, 1, 3'd5, 3'd2, 1, 3'd5, 1, 0, 1, 4'h1, 4'h2};
        vecs[4]  = '{0, 0, 0, 1, 3'd6, 3'd1, 1, 3'd6, 0, 0, 0, 4'h0, 4'h0};
        vecs[5]  = '{0, 0, 0, 0, 3'd4, 3'd4, 1, 3'd4, 1, 0, 0, 4'h0, 4'h0};
        vecs[6]  = '{0, 0, 0, 1, 3'd0, 3'd0, 1, 3'd7, 0, 0, 1, 4'h1, 4'h2};
        vecs[7]  = '{0, 1, 0, 0, 3'd0, 3'd1, 0, 3'd2, 0, 0, 1, 4'hF, 4'h0};
        vecs[8]  = '{0, 0, 1, 1, 3'd2, 3'd2, 1, 3'd2, 1, 1, 1, 4'hF, 4'h0};
        vecs[9]  = '{0, 0, 0, 1, 3'd2, 3'd2, 1, 3'd0, 0, 1, 0, 4'h0, 4'h3};
        vecs[10] = '{0, 0, 0, 0, 3'd0, 3'd1, 0, 3'd2, 0, 1, 0, 4'h0, 4'h3};

        drive(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0);
        step(1);

        // decode table against the single-bubble instance
        for (int v = 0; v < 11; v++) begin
            drive(vecs[v].r, vecs[v].fs, vecs[v].ms, vecs[v].mr, vecs[v].rd, vecs[v].rs,
                  vecs[v].rsv, vecs[v].rt, vecs[v].rtv, vecs[v].fl, 0);
            step(1);
            chk($sformatf("vec%0d pc_hold", v), 32'(s_pc[0]), 32'(vecs[v].e_pc));
            chk($sformatf("vec%0d hold", v), 32'(s_hold[0]), 32'(vecs[v].e_hold));
            chk($sformatf("vec%0d bubble", v), 32'(s_bub[0]), 32'(vecs[v].e_bub));
        end

        // single-bubble load-use: one hold cycle, stall_cnt becomes 1
        drive(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0); step(1);
        drive(0, 0, 0, 1, 3'd3, 3'd3, 1, 3'd0, 0, 0, 0); step(1);
        chk("lu1 pc_hold", 32'(s_pc[0]), 32'd1);
        chk("lu1 bubble", 32'(s_bub[0]), 32'h2);
        idle(); step(1);
        chk("lu1 after pc_hold", 32'(s_pc[0]), 32'd0);
        chk("lu1 stall_cnt", 32'(s_cnt[0]), 32'd1);

        // three-bubble hazard interleaved with two memory-stall cycles
        drive(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0); step(1);
        nbub = 0;
        drive(0, 0, 0, 1, 3'd4, 3'd1, 0, 3'd4, 1, 0, 0); step(1);
        nbub += int'(s_bub[1][1]);
        drive(0, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0); step(1);
        nbub += int'(s_bub[1][1]);
        chk("lu3 stall hold", 32'(s_hold[1]), 32'h3F);
        step(1);
        nbub += int'(s_bub[1][1]);
        chk("lu3 stall hold2", 32'(s_hold[1]), 32'h3F);
        for (int k = 0; k < 3; k++) begin
            idle(); step(1);
            nbub += int'(s_bub[1][1]);
        end
        chk("lu3 bubble count", 32'(nbub), 32'd3);
        chk("lu3 stall_cnt", 32'(s_cnt[1]), 32'd5);

        // flush in first wait cycle aborts the remaining bubbles
        drive(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0); step(1);
        drive(0, 0, 0, 1, 3'd2, 3'd2, 1, 3'd0, 0, 0, 0); step(1);
        drive(0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 0); step(1);
        chk("flush lu_busy before", 32'(s_busy[1]), 32'd1);
        chk("flush bubble", 32'(s_bub[1]), 32'h03);
        idle(); step(1);
        chk("flush lu_busy after", 32'(s_busy[1]), 32'd0);
        chk("flush no bubble", 32'(s_bub[1]), 32'h00);

        // flush under fetch stall is ignored; FSM stays in wait
        drive(0, 0, 0, 1, 3'd2, 3'd2, 1, 3'd0, 0, 0, 0); step(1);
        drive(0, 1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 0); step(1);
        chk("stall+flush hold", 32'(s_hold[1]), 32'h3F);
        chk("stall+flush bubble", 32'(s_bub[1]), 32'h00);
        drive(0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 0); step(1);
        chk("stall+flush busy kept", 32'(s_busy[1]), 32'd1);
        chk("flush next bubble", 32'(s_bub[1]), 32'h03);
        idle(); step(1);
        chk("flush next busy", 32'(s_busy[1]), 32'd0);

        // reset in the middle of a wait leaves nothing behind
        drive(0, 0, 0, 1, 3'd6, 3'd6, 1, 3'd0, 0, 0, 0); step(1);
        drive(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0); step(1);
        chk("rst busy", 32'(s_busy[1]), 32'd0);
        chk("rst bubble", 32'(s_bub[1]), 32'h3F);
        idle(); step(1);
        chk("post-rst pc_hold", 32'(s_pc[1]), 32'd0);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] rd;
            rd = 3'($urandom_range(0, 7));
            drive(($urandom % 100) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0,
                  ($urandom % 2) == 0, rd,
                  (($urandom % 3) == 0) ? rd : 3'($urandom_range(0, 7)), ($urandom % 4) != 0,
                  (($urandom % 3) == 0) ? rd : 3'($urandom_range(0, 7)), ($urandom % 4) != 0,
                  ($urandom % 10) == 0, ($urandom % 50) == 0);
            step(1);
        end

        // counter saturation and clear-wins
        drive(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0); step(1);
        drive(0, 1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0);
        for (int k = 0; k < 65534; k++) step(0);
        step(1);
        chk("sat preload", 32'(s_cnt[1]), 32'hFFFE);
        step(1);
        step(1);
        chk("sat reach", 32'(s_cnt[1]), 32'hFFFF);
        drive(0, 1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1); step(1);
        chk("sat hold", 32'(s_cnt[1]), 32'hFFFF);
        chk("clr with pc_hold", 32'(s_pc[1]), 32'd1);
        idle(); step(1);
        chk("clr result", 32'(s_cnt[1]), 32'd0);
        chk("clr result a", 32'(s_cnt[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
